counter_ctrl: RTL and testbench



---
 rtl/counter_ctrl_pkg.sv | 22 ++
 rtl/counter_prescaler.sv | 31 +++
 rtl/counter_ctrl.sv | 165 ++++++++++++++++
 tb/tb_counter_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the tick counter controller: command opcodes,
// FSM state encoding and default widths.
package counter_ctrl_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_PAUSE = 2'd2,
    OP_LOAD  = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/counter_prescaler.sv
// Clock prescaler: counts 0..presc while enabled and flags a tick on the
// cycle it reaches presc. en=0 freezes the phase, clr zeroes it.
module counter_prescaler
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] presc,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign tick = en && (cnt_q == presc);

  // Prescale phase counter; clear has priority over advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller for the tick counter: start/stop/pause/load
// commands, programmable prescaler, one-shot or auto-reload terminal count.
// Optional macro COUNTER_CTRL_IRQ_LATCH_EN adds a sticky irq with irq_ack.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic [PRESCALE_W-1:0] presc,
  input  logic                  auto_reload,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_o
`ifdef COUNTER_CTRL_IRQ_LATCH_EN
  ,
  output logic                  irq,
  input  logic                  irq_ack
`endif
);

  state_t                state_q, state_n;
  logic [WIDTH-1:0]      count_q, count_n;
  logic [WIDTH-1:0]      term_q, term_n;
  logic [PRESCALE_W-1:0] presc_q, presc_n;
  logic                  ar_q, ar_n;
  logic                  done_q, done_n;
  logic                  busy_q, busy_n;
  logic                  pre_clr;
  logic                  tick;
  cmd_op_t               op;

  assign op        = cmd_op_t'(cmd_op);
  assign cmd_ready = 1'b1;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_o   = state_q;

  counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == ST_RUN),
    .clr   (pre_clr),
    .presc (presc_q),
    .tick  (tick)
  );

  // Register all controller state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      term_q  <= '1;
      presc_q <= '0;
      ar_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      term_q  <= term_n;
      presc_q <= presc_n;
      ar_q    <= ar_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
    end
  end

  // Command decode and tick handling; LOAD is state-independent and, unlike
  // other commands, does not discard a coincident tick (old term compared).
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    term_n  = term_q;
    presc_n = presc_q;
    ar_n    = ar_q;
    done_n  = 1'b0;
    pre_clr = 1'b0;
    if (cmd_valid && (op == OP_LOAD)) term_n = cmd_data;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmd_valid) begin
          case (op)
            OP_START: begin
              state_n = ST_RUN;
              count_n = '0;
              presc_n = presc;
              ar_n    = auto_reload;
              pre_clr = 1'b1;
            end
            OP_STOP: begin
              state_n = ST_IDLE;
              count_n = '0;
              pre_clr = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cmd_valid && (op != OP_LOAD)) begin
          case (op)
            OP_START: begin
              count_n = '0;
              presc_n = presc;
              ar_n    = auto_reload;
              pre_clr = 1'b1;
            end
            OP_STOP: begin
              state_n = ST_IDLE;
              count_n = '0;
              pre_clr = 1'b1;
            end
            OP_PAUSE: state_n = ST_PAUSED;
            default: ;
          endcase
        end else if (tick) begin
          if (count_q == term_q) begin
            done_n = 1'b1;
            if (ar_q) count_n = '0;
            else      state_n = ST_DONE;
          end else begin
            count_n = count_q + 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        if (cmd_valid) begin
          case (op)
            OP_START: state_n = ST_RUN;
            OP_STOP: begin
              state_n = ST_IDLE;
              count_n = '0;
              pre_clr = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n == ST_RUN) || (state_n == ST_PAUSED);
  end

`ifdef COUNTER_CTRL_IRQ_LATCH_EN
  logic irq_q;
  assign irq = irq_q;

  // Sticky interrupt: set by a done pulse, cleared by ack; set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          irq_q <= 1'b0;
    else if (done_n)  irq_q <= 1'b1;
    else if (irq_ack) irq_q <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: table-driven first scenario,
// hand-written sequences for the rest, expectations via a scoreboard queue.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [3:0] presc = 4'd0;
  logic       auto_reload = 1'b0;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic [1:0] state_o;
`ifdef COUNTER_CTRL_IRQ_LATCH_EN
  logic       irq;
  logic       irq_ack = 1'b0;
`endif

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .presc       (presc),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .state_o     (state_o)
`ifdef COUNTER_CTRL_IRQ_LATCH_EN
    ,
    .irq         (irq),
    .irq_ack     (irq_ack)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       chk;
    logic [7:0] cnt;
    logic [1:0] st;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [7:0] d;
    logic [3:0] p;
    logic       ar;
    logic [7:0] c;
    logic [1:0] s;
    logic       b;
    logic       dn;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs 1ns after each edge against the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        cmp("count", 32'(count), 32'(e.cnt));
        cmp("state", 32'(state_o), 32'(e.st));
        cmp("busy", 32'(busy), 32'(e.busy));
        cmp("done", 32'(done), 32'(e.done));
        cmp("cmd_ready", 32'(cmd_ready), 32'd1);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic v, input logic [1:0] op, input logic [7:0] d,
                     input logic [3:0] p, input logic ar, input logic [7:0] c,
                     input logic [1:0] s, input logic b, input logic dn);
    exp_t e;
    @(posedge clk);
    #2;
    cmd_valid   = v;
    cmd_op      = op;
    cmd_data    = d;
    presc       = p;
    auto_reload = ar;
    e.chk = 1'b1; e.cnt = c; e.st = s; e.busy = b; e.done = dn;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [7:0] c, input logic [1:0] s, input logic b, input logic dn);
    cyc(1'b0, 2'd0, 8'd0, 4'd0, 1'b0, c, s, b, dn);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, OP_LOAD,  8'd5, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0};
    tbl[1] = '{1'b1, OP_START, 8'd0, 4'd0, 1'b0, 8'd0, ST_RUN,  1'b1, 1'b0};
    tbl[2] = '{1'b0, OP_START, 8'd0, 4'd0, 1'b0, 8'd1, ST_RUN,  1'b1, 1'b0};
    tbl[3] = '{1'b0, OP_START, 8'd0, 4'd0, 1'b0, 8'd2, ST_RUN,  1'b1, 1'b0};
    tbl[4] = '{1'b0, OP_START, 8'd0, 4'd0, 1'b0, 8'd3, ST_RUN,  1'b1, 1'b0};
    tbl[5] = '{1'b0, OP_START, 8'd0, 4'd0, 1'b0, 8'd4, ST_RUN,  1'b1, 1'b0};
    tbl[6] = '{1'b0, OP_START, 8'd0, 4'd0, 1'b0, 8'd5, ST_RUN,  1'b1, 1'b0};
    tbl[7] = '{1'b0, OP_START, 8'd0, 4'd0, 1'b0, 8'd5, ST_DONE, 1'b0, 1'b1};

    // Reset values
    #12;
    cmp("rst_count", 32'(count), 32'd0);
    cmp("rst_state", 32'(state_o), 32'(ST_IDLE));
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_done", 32'(done), 32'd0);
    cmp("rst_ready", 32'(cmd_ready), 32'd1);
`ifdef COUNTER_CTRL_IRQ_LATCH_EN
    cmp("rst_irq", 32'(irq), 32'd0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;

    // One-shot, term 5, presc 0
    for (int i = 0; i < 8; i++)
      cyc(tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].p, tbl[i].ar, tbl[i].c, tbl[i].s, tbl[i].b, tbl[i].dn);
    for (int i = 0; i < 20; i++) idle(8'd5, ST_DONE, 1'b0, 1'b0);
    cyc(1'b1, OP_STOP, 8'd0, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0);

    // Auto-reload, term 3, presc 2: a step every 3 clks, done every 12
    cyc(1'b1, OP_LOAD, 8'd3, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0);
    cyc(1'b1, OP_START, 8'd0, 4'd2, 1'b1, 8'd0, ST_RUN, 1'b1, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      int t;
      logic dn;
      t  = k / 3;
      dn = (k % 3 == 0) && (t > 0) && (t % 4 == 0);
      idle(8'(t % 4), ST_RUN, 1'b1, dn);
    end
    cyc(1'b1, OP_STOP, 8'd0, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0);

    // Pause at count 4 for 10 cycles, resume keeps phase and latched presc
    cyc(1'b1, OP_LOAD, 8'd20, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0);
    cyc(1'b1, OP_START, 8'd0, 4'd2, 1'b0, 8'd0, ST_RUN, 1'b1, 1'b0);
    for (int k = 1; k <= 13; k++) idle(8'(k / 3), ST_RUN, 1'b1, 1'b0);
    cyc(1'b1, OP_PAUSE, 8'd0, 4'd0, 1'b0, 8'd4, ST_PAUSED, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) idle(8'd4, ST_PAUSED, 1'b1, 1'b0);
    cyc(1'b1, OP_START, 8'd0, 4'd0, 1'b1, 8'd4, ST_RUN, 1'b1, 1'b0);
    for (int j = 1; j <= 8; j++) idle(8'((14 + j) / 3), ST_RUN, 1'b1, 1'b0);
    cyc(1'b1, OP_STOP, 8'd0, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0);

    // term 0 matches on the first tick
    cyc(1'b1, OP_LOAD, 8'd0, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0);
    cyc(1'b1, OP_START, 8'd0, 4'd0, 1'b0, 8'd0, ST_RUN, 1'b1, 1'b0);
    idle(8'd0, ST_DONE, 1'b0, 1'b1);
    idle(8'd0, ST_DONE, 1'b0, 1'b0);
`ifdef COUNTER_CTRL_IRQ_LATCH_EN
    @(posedge clk);
    #3;
    cmp("irq_set", 32'(irq), 32'd1);
    irq_ack = 1'b1;
    @(posedge clk);
    #3;
    irq_ack = 1'b0;
    cmp("irq_ack", 32'(irq), 32'd0);
`endif
    cyc(1'b1, OP_STOP, 8'd0, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0);

    // LOAD below count during a tick: wraps through 255 to reach new term
    cyc(1'b1, OP_LOAD, 8'd200, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0);
    cyc(1'b1, OP_START, 8'd0, 4'd0, 1'b0, 8'd0, ST_RUN, 1'b1, 1'b0);
    for (int k = 1; k <= 50; k++) idle(8'(k), ST_RUN, 1'b1, 1'b0);
    cyc(1'b1, OP_LOAD, 8'd10, 4'd0, 1'b0, 8'd51, ST_RUN, 1'b1, 1'b0);
    for (int k = 52; k <= 266; k++) idle(8'(k), ST_RUN, 1'b1, 1'b0);
    idle(8'd10, ST_DONE, 1'b0, 1'b1);
    cyc(1'b1, OP_STOP, 8'd0, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0);

    // Asynchronous reset mid-run restores term to all-ones
    cyc(1'b1, OP_LOAD, 8'd10, 4'd0, 1'b0, 8'd0, ST_IDLE, 1'b0, 1'b0);
    cyc(1'b1, OP_START, 8'd0, 4'd0, 1'b1, 8'd0, ST_RUN, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) idle(8'(k), ST_RUN, 1'b1, 1'b0);
    @(posedge clk);
    #3;
`ifdef COUNTER_CTRL_IRQ_LATCH_EN
    cmp("irq_pre_rst", 32'(irq), 32'd1);
`endif
    rst = 1'b1;
    #1;
    cmp("arst_count", 32'(count), 32'd0);
    cmp("arst_state", 32'(state_o), 32'(ST_IDLE));
    cmp("arst_busy", 32'(busy), 32'd0);
`ifdef COUNTER_CTRL_IRQ_LATCH_EN
    cmp("arst_irq", 32'(irq), 32'd0);
`endif
    @(posedge clk);
    #3;
    cmp("arst_done", 32'(done), 32'd0);
    rst = 1'b0;
    cyc(1'b1, OP_START, 8'd0, 4'd0, 1'b0, 8'd0, ST_RUN, 1'b1, 1'b0);
    for (int k = 1; k <= 255; k++) idle(8'(k), ST_RUN, 1'b1, 1'b0);
    idle(8'd255, ST_DONE, 1'b0, 1'b1);

    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
